irq_controller: RTL

- SoC-side interrupt controller facing the SM83 core's interrupt interface.
- Holds the interrupt flag register IF (0xFF0F) and the interrupt enable register IE (0xFFFF).
- Latches peripheral request edges into IF and drives the CPU trigger vector CPU_IRQ_TRIG = IF & IE.
- Clears the IF bit named by the core's one-hot CPU_IRQ_ACK.

---
 rtl/irq_controller.sv | 72 +++++++
 1 files changed

// File: rtl/irq_controller.sv
// Interrupt flag (IF) / enable (IE) block for the SM83 core.
// It latches request edges, raises IF & IE to the core and clears IF bits on one-hot acks.
module irq_controller #(
  parameter int unsigned NUM_IRQ = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic               CLK,
  input  logic               nSYNC_RES,
  input  logic [15:0]        A,
  input  logic [7:0]         D_IN,
  output logic [7:0]         D_OUT,
  input  logic               RD,
  input  logic               WR,
  input  logic [NUM_IRQ-1:0] IRQ_REQ,
  output logic [7:0]         CPU_IRQ_TRIG,
  input  logic [7:0]         CPU_IRQ_ACK
);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] req_prev_q, req_prev_d;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [7:0]         ie_q, ie_d;
  logic               if_wr, ie_wr;
  logic               unused_ack;

  // Ack bits at or above NUM_IRQ have no flag behind them.
  assign unused_ack = ^CPU_IRQ_ACK;

  always_comb begin
    if_wr      = WR & (A == IF_ADDR);
    ie_wr      = WR & (A == IE_ADDR);
    irq_edge   = IRQ_REQ & ~req_prev_q;
    req_prev_d = IRQ_REQ;
    if_d       = if_q;
    // A new request edge outranks a CPU write, which outranks an ack.
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (irq_edge[i]) begin
        if_d[i] = 1'b1;
      end else if (if_wr) begin
        if_d[i] = D_IN[i];
      end else if (CPU_IRQ_ACK[i]) begin
        if_d[i] = 1'b0;
      end
    end
    ie_d = ie_wr ? D_IN : ie_q;
  end

  always_ff @(posedge CLK) begin
    if (!nSYNC_RES) begin
      if_q       <= '0;
      ie_q       <= '0;
      req_prev_q <= IRQ_REQ;  // lines already high at release must not look like edges
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      req_prev_q <= req_prev_d;
    end
  end

  always_comb begin
    CPU_IRQ_TRIG                = '0;
    CPU_IRQ_TRIG[NUM_IRQ-1:0]   = if_q & ie_q[NUM_IRQ-1:0];
    D_OUT                       = 8'hFF;
    if (RD && (A == IF_ADDR)) begin
      D_OUT[NUM_IRQ-1:0] = if_q;
    end else if (RD && (A == IE_ADDR)) begin
      D_OUT = ie_q;
    end
  end

endmodule
